// File: rtl/cabac_se_pkg.sv
// ---------------------------------------------------------------------------
// cabac_se_pkg
// Shared definitions for the CABAC syntax-element serializers.
//   SE_W / NUM_SE     : pair width and number of parallel pair slots per CU
//   *_MSB / *_LSB     : field positions inside one pair
//                       ([20:13] value, [12:9] bin count, [8:0] SE type)
//   se_state_t        : serializer FSM encoding (IDLE, SEND, DONE)
//   se_is_empty()     : an all-zero pair marks an unused slot
// ---------------------------------------------------------------------------
package cabac_se_pkg;

    localparam int SE_W   = 21;
    localparam int NUM_SE = 10;

    localparam int VALUE_MSB = 20;
    localparam int VALUE_LSB = 13;
    localparam int BIN_MSB   = 12;
    localparam int BIN_LSB   = 9;
    localparam int TYPE_MSB  = 8;
    localparam int TYPE_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } se_state_t;

    function automatic logic se_is_empty(input logic [SE_W-1:0] pair);
        return (pair == '0);
    endfunction

endpackage

// File: rtl/cabac_ffs10.sv
// ---------------------------------------------------------------------------
// cabac_ffs10
// Combinational find-first-set over a 10-bit mask (lowest index wins).
//   mask : input  10  request mask
//   idx  : output 4   index of the lowest set bit (0 when mask is empty)
//   any  : output 1   at least one bit of mask is set
// ---------------------------------------------------------------------------
module cabac_ffs10 (
    input  logic [9:0] mask,
    output logic [3:0] idx,
    output logic       any
);

    always_comb begin
        idx = '0;
        // Walk from the top down so the lowest set bit is written last.
        for (int k = 9; k >= 0; k--) begin
            if (mask[k]) begin
                idx = 4'(k);
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/cabac_se_intra_serializer.sv
// ---------------------------------------------------------------------------
// cabac_se_intra_serializer
// Captures the ten syntax-element pair slots of one intra CU on start_i,
// drops the all-zero slots and streams the rest in slot order to the CABAC
// binarizer, one pair per handshake.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   start_i                       : one-cycle start pulse, honoured only in IDLE
//   se_pair_0_i .. se_pair_9_i    : SE_W-bit pair slots (all-zero = empty)
//   se_pair_o, se_valid_o         : current pair and its valid flag
//   se_ready_i                    : binarizer ready
//   busy_o                        : CU being streamed
//   done_o                        : one-cycle pulse at end of CU
//   se_cnt_o                      : pairs issued for the current/last CU
//
// Handshake: a pair transfers on every cycle where se_valid_o and se_ready_i
// are both high. Once se_valid_o rises, se_pair_o and se_valid_o hold until
// that transfer happens; se_pair_o reads zero whenever se_valid_o is low.
// ---------------------------------------------------------------------------
module cabac_se_intra_serializer
    import cabac_se_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [SE_W-1:0] se_pair_0_i,
    input  logic [SE_W-1:0] se_pair_1_i,
    input  logic [SE_W-1:0] se_pair_2_i,
    input  logic [SE_W-1:0] se_pair_3_i,
    input  logic [SE_W-1:0] se_pair_4_i,
    input  logic [SE_W-1:0] se_pair_5_i,
    input  logic [SE_W-1:0] se_pair_6_i,
    input  logic [SE_W-1:0] se_pair_7_i,
    input  logic [SE_W-1:0] se_pair_8_i,
    input  logic [SE_W-1:0] se_pair_9_i,
    output logic [SE_W-1:0] se_pair_o,
    output logic            se_valid_o,
    input  logic            se_ready_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [3:0]      se_cnt_o
);

    logic [SE_W-1:0]   slot_in [NUM_SE];
    logic [SE_W-1:0]   buf_q   [NUM_SE];
    logic [NUM_SE-1:0] start_mask;
    logic [NUM_SE-1:0] mask_q, mask_d;
    logic [NUM_SE-1:0] sel_onehot;
    logic [3:0]        sel_idx;
    logic              sel_any;
    logic [3:0]        cnt_q, cnt_d;
    logic              load;
    se_state_t         state_q, state_d;

    assign slot_in[0] = se_pair_0_i;
    assign slot_in[1] = se_pair_1_i;
    assign slot_in[2] = se_pair_2_i;
    assign slot_in[3] = se_pair_3_i;
    assign slot_in[4] = se_pair_4_i;
    assign slot_in[5] = se_pair_5_i;
    assign slot_in[6] = se_pair_6_i;
    assign slot_in[7] = se_pair_7_i;
    assign slot_in[8] = se_pair_8_i;
    assign slot_in[9] = se_pair_9_i;

    always_comb begin
        start_mask = '0;
        for (int k = 0; k < NUM_SE; k++) begin
            start_mask[k] = !se_is_empty(slot_in[k]);
        end
    end

    // Pending mask selects the next pair; empty slots never get a mask bit,
    // so they cost no cycles.
    cabac_ffs10 u_ffs (
        .mask (mask_q),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    assign sel_onehot = NUM_SE'(1) << sel_idx;

    // Outputs come from flops and the selection mux only.
    assign se_valid_o = (state_q == ST_SEND) && sel_any;
    assign se_pair_o  = se_valid_o ? buf_q[sel_idx] : '0;
    assign busy_o     = (state_q == ST_SEND);
    assign done_o     = (state_q == ST_DONE);
    assign se_cnt_o   = cnt_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    mask_d  = start_mask;
                    cnt_d   = '0;
                    state_d = (|start_mask) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (se_ready_i) begin
                    mask_d = mask_q & ~sel_onehot;
                    cnt_d  = 4'(cnt_q + 4'd1);
                    if (mask_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_SE; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            if (load) begin
                for (int k = 0; k < NUM_SE; k++) begin
                    buf_q[k] <= slot_in[k];
                end
            end
        end
    end

endmodule
